block_mem_responder: RTL and testbench

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/block_mem_defs.sv | 22 ++
 rtl/block_mem_array.sv | 28 ++
 rtl/block_mem_responder.sv | 116 +++++++++++
 tb/tb_block_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_defs.sv
// Shared widths, default timing and state/kind encodings for the block memory responder.
// Pure definitions; no latency, no backpressure.
package block_mem_defs;

    localparam int BLOCK_W         = 256;
    localparam int OFFSET_BITS     = 5;
    localparam int DEFAULT_LATENCY = 8;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memState_t;

    typedef enum logic [1:0] {
        KIND_IREAD  = 2'd0,
        KIND_DREAD  = 2'd1,
        KIND_DWRITE = 2'd2
    } reqKind_t;

endpackage

// File: rtl/block_mem_array.sv
// Block storage, DEPTH_BLOCKS x BLOCK_W; write lands on the clock edge, read is combinational.
// No backpressure: the single caller owns both ports every cycle.
module block_mem_array
    import block_mem_defs::*;
#(
    parameter  int DEPTH_BLOCKS = 64,
    localparam int IDX_W        = $clog2(DEPTH_BLOCKS)
) (
    input  logic               CLK,
    input  logic               wrEn,
    input  logic [IDX_W-1:0]   wrIdx,
    input  logic [BLOCK_W-1:0] wrData,
    input  logic [IDX_W-1:0]   rdIdx,
    output logic [BLOCK_W-1:0] rdData
);

    logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];

    // Contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/block_mem_responder.sv
// Fixed-latency block memory serving one instruction and one data requester, one transaction at a time.
// Valid pulses LATENCY cycles after acceptance; requests are only sampled in IDLE (busy high otherwise).
module block_mem_responder
    import block_mem_defs::*;
#(
    parameter int LATENCY      = DEFAULT_LATENCY,
    parameter int DEPTH_BLOCKS = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               iBlkRead,
    input  logic [31:0]        Instr_address_2IM,
    output logic [BLOCK_W-1:0] block_read_fIM,
    output logic               block_read_fIM_valid,
    input  logic               dBlkRead,
    input  logic               dBlkWrite,
    input  logic [31:0]        data_address_2DM,
    input  logic [BLOCK_W-1:0] block_write_2DM,
    output logic [BLOCK_W-1:0] block_read_fDM,
    output logic               block_read_fDM_valid,
    output logic               block_write_fDM_valid,
    output logic               busy
);

    localparam int               IDX_W    = $clog2(DEPTH_BLOCKS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    memState_t          state, stateNext;
    reqKind_t           kind, kindSel, curKind;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   blkIdx, idxSel, curIdx;
    logic [BLOCK_W-1:0] wrData, curWrData, memRdData;
    logic               reqAny, enterResp, memWrEn;
    logic               unusedAddrBits;

    assign unusedAddrBits = ^{Instr_address_2IM[31:OFFSET_BITS+IDX_W], Instr_address_2IM[OFFSET_BITS-1:0],
                              data_address_2DM[31:OFFSET_BITS+IDX_W], data_address_2DM[OFFSET_BITS-1:0]};

    // Write beats data read beats instruction read.
    always_comb begin
        reqAny  = dBlkWrite | dBlkRead | iBlkRead;
        kindSel = KIND_IREAD;
        idxSel  = Instr_address_2IM[OFFSET_BITS +: IDX_W];
        if (dBlkWrite) begin
            kindSel = KIND_DWRITE;
            idxSel  = data_address_2DM[OFFSET_BITS +: IDX_W];
        end else if (dBlkRead) begin
            kindSel = KIND_DREAD;
            idxSel  = data_address_2DM[OFFSET_BITS +: IDX_W];
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (reqAny) stateNext = (CNT_LOAD == '0) ? RESP : WAIT;
            WAIT:    if (count <= CNT_W'(1)) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // With LATENCY=1 RESP is entered straight from IDLE, before the latches hold the request.
    always_comb begin
        curKind   = (state == IDLE) ? kindSel : kind;
        curIdx    = (state == IDLE) ? idxSel : blkIdx;
        curWrData = (state == IDLE) ? block_write_2DM : wrData;
        enterResp = (stateNext == RESP);
        memWrEn   = enterResp && (curKind == KIND_DWRITE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            count          <= '0;
            kind           <= KIND_IREAD;
            blkIdx         <= '0;
            wrData         <= '0;
            block_read_fIM <= '0;
            block_read_fDM <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && reqAny) begin
                kind   <= kindSel;
                blkIdx <= idxSel;
                wrData <= block_write_2DM;
                count  <= CNT_LOAD;
            end else if (state == WAIT) begin
                count <= count - CNT_W'(1);
            end
            if (enterResp && curKind == KIND_IREAD) begin
                block_read_fIM <= memRdData;
            end
            if (enterResp && curKind == KIND_DREAD) begin
                block_read_fDM <= memRdData;
            end
        end
    end

    assign busy                  = (state != IDLE);
    assign block_read_fIM_valid  = (state == RESP) && (kind == KIND_IREAD);
    assign block_read_fDM_valid  = (state == RESP) && (kind == KIND_DREAD);
    assign block_write_fDM_valid = (state == RESP) && (kind == KIND_DWRITE);

    block_mem_array #(
        .DEPTH_BLOCKS(DEPTH_BLOCKS)
    ) uMem (
        .CLK    (CLK),
        .wrEn   (memWrEn),
        .wrIdx  (curIdx),
        .wrData (curWrData),
        .rdIdx  (curIdx),
        .rdData (memRdData)
    );

endmodule

// File: tb/tb_block_mem_responder.sv
// Bench for block_mem_responder: LATENCY=8 instance driven by vectors and random requests,
// plus a LATENCY=1 instance for back-to-back service.
module tb_block_mem_responder;

    localparam int LAT   = 8;
    localparam int DEPTH = 64;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic         iBlkRead, dBlkRead, dBlkWrite;
    logic [31:0]  iAddr, dAddr;
    logic [255:0] wData, fIM, fDM;
    logic         fIMV, fDMV, fDWV, busy;

    logic         iBlkRead1, dBlkRead1, dBlkWrite1;
    logic [31:0]  iAddr1, dAddr1;
    logic [255:0] wData1, fIM1, fDM1;
    logic         fIMV1, fDMV1, fDWV1, busy1;

    block_mem_responder #(.LATENCY(LAT), .DEPTH_BLOCKS(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .iBlkRead(iBlkRead), .Instr_address_2IM(iAddr),
        .block_read_fIM(fIM), .block_read_fIM_valid(fIMV),
        .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite),
        .data_address_2DM(dAddr), .block_write_2DM(wData),
        .block_read_fDM(fDM), .block_read_fDM_valid(fDMV),
        .block_write_fDM_valid(fDWV), .busy(busy)
    );

    block_mem_responder #(.LATENCY(1), .DEPTH_BLOCKS(DEPTH)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .iBlkRead(iBlkRead1), .Instr_address_2IM(iAddr1),
        .block_read_fIM(fIM1), .block_read_fIM_valid(fIMV1),
        .dBlkRead(dBlkRead1), .dBlkWrite(dBlkWrite1),
        .data_address_2DM(dAddr1), .block_write_2DM(wData1),
        .block_read_fDM(fDM1), .block_read_fDM_valid(fDMV1),
        .block_write_fDM_valid(fDWV1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    logic [255:0] modelMem [DEPTH];
    logic [255:0] lastIM, lastDM;

    typedef struct {
        bit           ri, rd, rw;
        logic [31:0]  ia, da;
        logic [255:0] wd;
        int           expFirst;   // 2 = data write, 1 = data read, 0 = instruction read
        logic [255:0] expData;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int blkOf(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Raise a set of requests, serve them in priority order; each response is due LAT cycles
    // after its acceptance, and the next one is accepted the cycle after the previous valid.
    task automatic runReqs(input bit ri, input bit rd, input bit rw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [255:0] wd, input int expFirst,
                           input logic [255:0] expData, input bit checkFirst);
        int pend[$];
        int n, expAt, busyCnt, served, obs, k, budget;
        bit first;
        budget = 4 * (LAT + 1) + 4;
        n = 0; expAt = LAT; busyCnt = 0; served = 0; first = 1'b1;
        if (rw) pend.push_back(2);
        if (rd) pend.push_back(1);
        if (ri) pend.push_back(0);
        @(negedge CLK);
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_valids", 256'({fIMV, fDMV, fDWV}), 256'(0));
        chk("hold_fIM", fIM, lastIM);
        chk("hold_fDM", fDM, lastDM);
        iBlkRead = ri; dBlkRead = rd; dBlkWrite = rw;
        iAddr = ia; dAddr = da; wData = wd;
        while (pend.size() > 0 && n < budget) begin
            @(negedge CLK);
            n++;
            if (busy) busyCnt++;
            if (fIMV | fDMV | fDWV) begin
                chk("single_valid", 256'(32'(fIMV) + 32'(fDMV) + 32'(fDWV)), 256'(1));
                obs = fDWV ? 2 : (fDMV ? 1 : 0);
                k = pend.pop_front();
                chk("serve_order", 256'(obs), 256'(k));
                chk("latency", 256'(n), 256'(expAt));
                if (first && checkFirst) begin
                    chk("vec_first_kind", 256'(obs), 256'(expFirst));
                    if (expFirst != 2) chk("vec_first_data", (expFirst == 1) ? fDM : fIM, expData);
                end
                first = 1'b0;
                case (k)
                    2: begin
                        modelMem[blkOf(da)] = wd;
                        dBlkWrite = 1'b0;
                    end
                    1: begin
                        lastDM = modelMem[blkOf(da)];
                        chk("dm_data", fDM, lastDM);
                        dBlkRead = 1'b0;
                    end
                    default: begin
                        lastIM = modelMem[blkOf(ia)];
                        chk("im_data", fIM, lastIM);
                        iBlkRead = 1'b0;
                    end
                endcase
                served++;
                expAt = n + 1 + LAT;
            end
        end
        if (pend.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d requests unserved after %0d cycles", pend.size(), n);
            iBlkRead = 1'b0; dBlkRead = 1'b0; dBlkWrite = 1'b0;
            repeat (LAT + 2) @(negedge CLK);
        end
        chk("busy_cycles", 256'(busyCnt), 256'(served * LAT));
    endtask

    vec_t vecs[8];
    logic [255:0] patA, patB, patC, patD, patP, patQ, patE;

    initial begin
        logic [31:0] addr, m;
        patA = {8{32'hA5A5_0001}};
        patB = {8{32'hB0B0_0002}};
        patC = {8{32'hC3C3_0003}};
        patD = {4{64'hD00D_1234_5678_9ABC}};
        patP = {8{32'h1357_9BDF}};
        patQ = {8{32'h2468_ACE0}};
        patE = {8{32'hE1E1_0005}};
        vecs[0] = '{0, 0, 1, 32'h0, 32'h0000_0040, patA, 2, '0};
        vecs[1] = '{1, 0, 0, 32'h0000_0040, 32'h0, '0, 0, patA};
        vecs[2] = '{0, 0, 1, 32'h0, 32'h0000_0060, patB, 2, '0};
        vecs[3] = '{0, 1, 0, 32'h0, 32'h0000_007C, '0, 1, patB};
        vecs[4] = '{0, 0, 1, 32'h0, 32'h0000_0800, patC, 2, '0};
        vecs[5] = '{0, 1, 0, 32'h0, 32'h0000_0000, '0, 1, patC};
        vecs[6] = '{1, 1, 0, 32'h0000_0060, 32'h0000_0040, '0, 1, patA};
        vecs[7] = '{1, 1, 1, 32'h0000_0020, 32'h0000_0020, patD, 2, '0};

        RESET = 1'b0;
        iBlkRead = 0; dBlkRead = 0; dBlkWrite = 0; iAddr = 0; dAddr = 0; wData = 0;
        iBlkRead1 = 0; dBlkRead1 = 0; dBlkWrite1 = 0; iAddr1 = 0; dAddr1 = 0; wData1 = 0;
        lastIM = '0; lastDM = '0;
        repeat (2) @(negedge CLK);
        chk("reset_busy", 256'({busy, busy1}), 256'(0));
        chk("reset_valids", 256'({fIMV, fDMV, fDWV, fIMV1, fDMV1, fDWV1}), 256'(0));
        chk("reset_fIM", fIM, '0);
        chk("reset_fDM", fDM, '0);
        RESET = 1'b1;

        // Preload every block, with junk in the ignored address bits.
        for (int i = 0; i < DEPTH; i++) begin
            addr = ($urandom & ~32'h0000_07E0) | (32'(i) << 5);
            runReqs(0, 0, 1, 32'h0, addr, rand256(), 2, '0, 1'b1);
        end

        for (int v = 0; v < 8; v++) begin
            runReqs(vecs[v].ri, vecs[v].rd, vecs[v].rw, vecs[v].ia, vecs[v].da,
                    vecs[v].wd, vecs[v].expFirst, vecs[v].expData, 1'b1);
        end

        for (int r = 0; r < 40; r++) begin
            m = $urandom_range(1, 7);
            runReqs(m[0], m[1], m[2], $urandom, $urandom, rand256(), 0, '0, 1'b0);
        end

        // Reset during the third WAIT cycle of a write aborts it.
        runReqs(0, 0, 1, 32'h0, 32'h0000_00A0, patP, 2, '0, 1'b1);
        @(negedge CLK);
        dBlkWrite = 1'b1; dAddr = 32'h0000_00A0; wData = patQ;
        repeat (3) @(negedge CLK);
        chk("busy_before_abort", 256'(busy), 256'(1));
        RESET = 1'b0;
        #1;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_valids", 256'({fIMV, fDMV, fDWV}), 256'(0));
        chk("abort_fIM", fIM, '0);
        chk("abort_fDM", fDM, '0);
        dBlkWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("abort_quiet", 256'({fIMV, fDMV, fDWV, busy}), 256'(0));
        end
        RESET = 1'b1;
        lastIM = '0; lastDM = '0;
        runReqs(0, 1, 0, 32'h0, 32'h0000_00A0, '0, 1, patP, 1'b1);

        // LATENCY=1: a held request is served every other cycle.
        @(negedge CLK);
        dBlkWrite1 = 1'b1; dAddr1 = 32'h0000_0040; wData1 = patE;
        @(negedge CLK);
        chk("l1_write_valid", 256'({fIMV1, fDMV1, fDWV1}), 256'(1));
        dBlkWrite1 = 1'b0;
        @(negedge CLK);
        iBlkRead1 = 1'b1; iAddr1 = 32'h0000_0040;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            chk("l1_valid", 256'({fIMV1, fDMV1, fDWV1}), 256'({n % 2 == 1, 2'b00}));
            chk("l1_busy", 256'(busy1), 256'(n % 2 == 1));
            if (fIMV1) chk("l1_data", fIM1, patE);
        end
        iBlkRead1 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("l1_idle", 256'({busy1, fIMV1}), 256'(0));
        chk("l1_hold", fIM1, patE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
